// File: rtl/udp_pkg.sv
// Shared constants, state encodings and header-word helper for the UDP receive stage.
package udp_pkg;

  localparam logic [15:0] UDP_HEAD_BYTES = 16'd8;
  localparam int          PORT_W         = 16;
  localparam int          UDP_LEN_W      = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // Header words arrive first-byte-low; the field value is big-endian.
  function automatic logic [15:0] field_swap(input logic [15:0] word);
    return {word[7:0], word[15:8]};
  endfunction

endpackage

// File: rtl/udp_rx.sv
// UDP receive stage: parses the 8-byte header, filters on ports and IPv4 checksum error,
// and forwards the datagram payload with registered start/length/cancel framing.
module udp_rx
  import udp_pkg::*;
#(
  parameter int                DATA_W         = 16,
  parameter bit                MATCH_DST_PORT = 1'b1,
  parameter logic [PORT_W-1:0] DST_PORT       = 16'd5000,
  parameter bit                MATCH_SRC_PORT = 1'b0,
  parameter logic [PORT_W-1:0] SRC_PORT       = 16'd5001,
  localparam int               LEN_W          = $clog2(DATA_W/8+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              cancel_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              cs_err_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              cancel_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [PORT_W-1:0] src_port_o,
  output logic              drop_o
);

  logic [1:0]           state_q, state_d;
  logic [1:0]           hdr_idx_q, hdr_idx_d;
  logic [UDP_LEN_W-1:0] rem_q, rem_d;
  logic                 first_q, first_d;
  logic [PORT_W-1:0]    src_q, src_d;
  logic                 valid_q, valid_d;
  logic                 start_q, start_d;
  logic                 cancel_q, cancel_d;
  logic                 drop_q, drop_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [LEN_W-1:0]     len_q, len_d;

  logic [15:0]      field_s;
  logic [LEN_W-1:0] beat_len_s;
  logic             unused_s;

  assign field_s    = field_swap(data_i);
  assign beat_len_s = (rem_q >= 16'd2) ? LEN_W'(2) : LEN_W'(1);
  // Beat byte counts are derived from the UDP length, so upstream len_i is informational only.
  assign unused_s   = ^len_i;

  // Next-state, header parsing, filtering and output framing.
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    rem_d     = rem_q;
    first_d   = first_q;
    src_d     = src_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    cancel_d  = 1'b0;
    drop_d    = 1'b0;
    data_d    = data_q;
    len_d     = len_q;

    if (cancel_i) begin
      state_d  = S_IDLE;
      cancel_d = (state_q == S_DATA);
    end else if (valid_i && start_i) begin
      // A start beat always opens a new packet, abandoning whatever was in flight.
      cancel_d = (state_q == S_DATA);
      if (cs_err_i || (MATCH_SRC_PORT && (field_s != SRC_PORT))) begin
        state_d = S_IDLE;
        drop_d  = 1'b1;
      end else begin
        state_d   = S_HEAD;
        hdr_idx_d = 2'd1;
        src_d     = field_s;
      end
    end else if (valid_i) begin
      case (state_q)
        S_HEAD: begin
          if (cs_err_i) begin
            state_d = S_IDLE;
            drop_d  = 1'b1;
          end else begin
            case (hdr_idx_q)
              2'd1: begin
                if (MATCH_DST_PORT && (field_s != DST_PORT)) begin
                  state_d = S_IDLE;
                  drop_d  = 1'b1;
                end else begin
                  hdr_idx_d = 2'd2;
                end
              end
              2'd2: begin
                if (field_s < UDP_HEAD_BYTES) begin
                  state_d = S_IDLE;
                  drop_d  = 1'b1;
                end else begin
                  rem_d     = field_s - UDP_HEAD_BYTES;
                  hdr_idx_d = 2'd3;
                end
              end
              2'd3: begin
                if (rem_q == 16'd0) begin
                  state_d = S_IDLE;
                end else begin
                  state_d = S_DATA;
                  first_d = 1'b1;
                end
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end
        S_DATA: begin
          if (cs_err_i) begin
            state_d  = S_IDLE;
            cancel_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            start_d = first_q;
            first_d = 1'b0;
            data_d  = data_i;
            len_d   = beat_len_s;
            rem_d   = rem_q - {{(UDP_LEN_W-LEN_W){1'b0}}, beat_len_s};
            if (rem_q <= 16'd2) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hdr_idx_q <= 2'd0;
      rem_q     <= 16'd0;
      first_q   <= 1'b0;
      src_q     <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      cancel_q  <= 1'b0;
      drop_q    <= 1'b0;
      data_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      src_q     <= src_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      cancel_q  <= cancel_d;
      drop_q    <= drop_d;
      data_q    <= data_d;
      len_q     <= len_d;
    end
  end

  assign valid_o    = valid_q;
  assign start_o    = start_q;
  assign cancel_o   = cancel_q;
  assign drop_o     = drop_q;
  assign data_o     = data_q;
  assign len_o      = len_q;
  assign src_port_o = src_q;

endmodule

// File: tb/tb_udp_rx.sv
// Directed, scoreboard-checked bench for udp_rx.
module tb_udp_rx;

  logic        clk;
  logic        reset;
  logic        valid_i, start_i, cancel_i, cs_err_i;
  logic [15:0] data_i;
  logic [1:0]  len_i;
  logic        valid_o, start_o, cancel_o, drop_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;
  logic [15:0] src_port_o;

  typedef struct {
    logic [1:0]  kind;   // 0 payload beat, 1 drop, 2 cancel
    logic        st;
    logic [15:0] data;
    logic [1:0]  len;
    logic [15:0] src;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  udp_rx dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .data_i     (data_i),
    .len_i      (len_i),
    .cs_err_i   (cs_err_i),
    .valid_o    (valid_o),
    .start_o    (start_o),
    .cancel_o   (cancel_o),
    .data_o     (data_o),
    .len_o      (len_o),
    .src_port_o (src_port_o),
    .drop_o     (drop_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] hdr(input logic [15:0] f);
    return {f[7:0], f[15:8]};
  endfunction

  task automatic exp_beat(input logic st, input logic [15:0] d, input logic [1:0] l, input logic [15:0] s);
    ev_t e;
    e.kind = 2'd0; e.st = st; e.data = d; e.len = l; e.src = s;
    sb.push_back(e);
  endtask

  task automatic exp_evt(input logic [1:0] kind);
    ev_t e;
    e.kind = kind; e.st = 1'b0; e.data = 16'd0; e.len = 2'd0; e.src = 16'd0;
    sb.push_back(e);
  endtask

  task automatic mon();
    ev_t e;
    logic [3:0] act;
    logic [3:0] expv;
    act = {valid_o, start_o, drop_o, cancel_o};
    if (act != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(act), 32'd0);
      end else begin
        e = sb.pop_front();
        expv = {e.kind == 2'd0, (e.kind == 2'd0) && e.st, e.kind == 2'd1, e.kind == 2'd2};
        chk("event_flags", 32'(act), 32'(expv));
        if (e.kind == 2'd0) begin
          chk("data_o", 32'(data_o), 32'(e.data));
          chk("len_o", 32'(len_o), 32'(e.len));
          chk("src_port_o", 32'(src_port_o), 32'(e.src));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic drive(input logic v, input logic s, input logic c, input logic [15:0] d,
                       input logic [1:0] l, input logic cs);
    valid_i = v; start_i = s; cancel_i = c; data_i = d; len_i = l; cs_err_i = cs;
    tick();
    valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0; cs_err_i = 1'b0;
  endtask

  // drop_at selects the header word (0..3) expected to trigger drop_o, -1 for none.
  task automatic send_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] ulen,
                          input int drop_at, input logic cs0);
    if (drop_at == 0) exp_evt(2'd1);
    drive(1'b1, 1'b1, 1'b0, hdr(src), 2'd2, cs0);
    if (drop_at == 1) exp_evt(2'd1);
    drive(1'b1, 1'b0, 1'b0, hdr(dst), 2'd2, 1'b0);
    if (drop_at == 2) exp_evt(2'd1);
    drive(1'b1, 1'b0, 1'b0, hdr(ulen), 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0; cs_err_i = 1'b0;
    data_i = 16'd0; len_i = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_start_o", 32'(start_o), 32'd0);
    chk("rst_cancel_o", 32'(cancel_o), 32'd0);
    chk("rst_drop_o", 32'(drop_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_len_o", 32'(len_o), 32'd0);
    chk("rst_src_port_o", 32'(src_port_o), 32'd0);
    reset = 1'b0;
    tick();

    // Accepted packet, payload 04 03 02 01, with an idle gap mid-payload
    send_hdr(16'd5001, 16'd5000, 16'd12, -1, 1'b0);
    exp_beat(1'b1, 16'h0304, 2'd2, 16'd5001);
    drive(1'b1, 1'b0, 1'b0, 16'h0304, 2'd2, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd2, 1'b0);
    exp_beat(1'b0, 16'h0102, 2'd2, 16'd5001);
    drive(1'b1, 1'b0, 1'b0, 16'h0102, 2'd2, 1'b0);

    // Wrong destination port: drop after word 1, payload ignored
    send_hdr(16'd5001, 16'd80, 16'd12, 1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h1111, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h2222, 2'd2, 1'b0);

    // Odd length 13 with two padding bytes (EE) trailing
    send_hdr(16'd1234, 16'd5000, 16'd13, -1, 1'b0);
    exp_beat(1'b1, 16'h0201, 2'd2, 16'd1234);
    drive(1'b1, 1'b0, 1'b0, 16'h0201, 2'd2, 1'b0);
    exp_beat(1'b0, 16'h0403, 2'd2, 16'd1234);
    drive(1'b1, 1'b0, 1'b0, 16'h0403, 2'd2, 1'b0);
    exp_beat(1'b0, 16'hEE05, 2'd1, 16'd1234);
    drive(1'b1, 1'b0, 1'b0, 16'hEE05, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h00EE, 2'd1, 1'b0);

    // Empty datagram, then an undersized length
    send_hdr(16'd7, 16'd5000, 16'd8, -1, 1'b0);
    send_hdr(16'd7, 16'd5000, 16'd6, 2, 1'b0);

    // Upstream cancel on the second payload beat, then a normal packet
    send_hdr(16'd42, 16'd5000, 16'd16, -1, 1'b0);
    exp_beat(1'b1, 16'hA1A0, 2'd2, 16'd42);
    drive(1'b1, 1'b0, 1'b0, 16'hA1A0, 2'd2, 1'b0);
    exp_evt(2'd2);
    drive(1'b1, 1'b0, 1'b1, 16'hA3A2, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'hA5A4, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'hA7A6, 2'd2, 1'b0);
    send_hdr(16'd43, 16'd5000, 16'd10, -1, 1'b0);
    exp_beat(1'b1, 16'hBEEF, 2'd2, 16'd43);
    drive(1'b1, 1'b0, 1'b0, 16'hBEEF, 2'd2, 1'b0);

    // IPv4 checksum error on the start beat
    send_hdr(16'd44, 16'd5000, 16'd12, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 16'h3333, 2'd2, 1'b0);

    // IPv4 checksum error during payload
    send_hdr(16'd45, 16'd5000, 16'd12, -1, 1'b0);
    exp_beat(1'b1, 16'h4544, 2'd2, 16'd45);
    drive(1'b1, 1'b0, 1'b0, 16'h4544, 2'd2, 1'b0);
    exp_evt(2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h4746, 2'd2, 1'b1);

    // New start mid-payload truncates the previous packet
    send_hdr(16'd46, 16'd5000, 16'd16, -1, 1'b0);
    exp_beat(1'b1, 16'h6160, 2'd2, 16'd46);
    drive(1'b1, 1'b0, 1'b0, 16'h6160, 2'd2, 1'b0);
    exp_evt(2'd2);
    send_hdr(16'd47, 16'd5000, 16'd10, -1, 1'b0);
    exp_beat(1'b1, 16'h7170, 2'd2, 16'd47);
    drive(1'b1, 1'b0, 1'b0, 16'h7170, 2'd2, 1'b0);

    // Cancel (without valid) during the header: silent return to idle
    drive(1'b1, 1'b1, 1'b0, hdr(16'd48), 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, hdr(16'd5000), 2'd2, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, hdr(16'd12), 2'd2, 1'b0);
    send_hdr(16'd49, 16'd5000, 16'd9, -1, 1'b0);
    exp_beat(1'b1, 16'h9990, 2'd1, 16'd49);
    drive(1'b1, 1'b0, 1'b0, 16'h9990, 2'd1, 1'b0);

    // Reset asserted mid-payload clears outputs without a clock edge
    send_hdr(16'd50, 16'd5000, 16'd12, -1, 1'b0);
    exp_beat(1'b1, 16'h5150, 2'd2, 16'd50);
    drive(1'b1, 1'b0, 1'b0, 16'h5150, 2'd2, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
    chk("mid_rst_start_o", 32'(start_o), 32'd0);
    chk("mid_rst_data_o", 32'(data_o), 32'd0);
    chk("mid_rst_len_o", 32'(len_o), 32'd0);
    chk("mid_rst_src_port_o", 32'(src_port_o), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h5352, 2'd2, 1'b0);
    send_hdr(16'd51, 16'd5000, 16'd10, -1, 1'b0);
    exp_beat(1'b1, 16'hC0DE, 2'd2, 16'd51);
    drive(1'b1, 1'b0, 1'b0, 16'hC0DE, 2'd2, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
